serv_bufreg2_seq: RTL

Sequencer for the bit-serial secondary buffer register used for stores, loads and shifts.
- Accepts one operation request at a time.
- Drives the buffer's enable, init, count-done, lane-select, byte-valid, shift-op and parallel-load controls through fixed 32-cycle serial phases.
- Runs the data-bus cycle in between and reports completion to the core state logic.

---
 rtl/serv_bufreg2_seq_pkg.sv | 36 +++
 rtl/serv_seq_cnt.sv | 47 ++++
 rtl/serv_bufreg2_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serv_bufreg2_seq_pkg.sv
// serv_bufreg2_seq_pkg
// Shared constants for the bufreg2 sequencer and its counter block.
// FSM state codes, operation and size codes, serial length, and an
// alignment helper.
package serv_bufreg2_seq_pkg;

    localparam int SER_LEN = 32;
    localparam int CNT_W   = $clog2(SER_LEN);

    // FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_MEM   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_TRAP  = 3'd5;

    // Operation codes (2'b11 is reserved and handled as a store)
    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Access size codes (2'b11 behaves as word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Half needs lsb[0]=0, word needs lsb=0; bytes are always aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        if (size == SZ_BYTE)      return 1'b0;
        else if (size == SZ_HALF) return lsb[0];
        else                      return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// serv_seq_cnt
// Serial position counter (0..SER_LEN-1, wraps) plus the bus wait counter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cnt_clr / cnt_en      clear has priority over count for the serial counter
//   cnt, cnt_done         serial position, high at the last serial bit
//   wait_clr / wait_en    clear has priority over count for the wait counter
//   wait_done             high during the TIMEOUT-th wait cycle (never if TIMEOUT=0)
module serv_seq_cnt
    import serv_bufreg2_seq_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_clr,
    input  logic             cnt_en,
    input  logic             wait_clr,
    input  logic             wait_en,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_done,
    output logic             wait_done
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            if (cnt_clr)     cnt <= '0;
            else if (cnt_en) cnt <= cnt + 1'b1;   // natural wrap 31 -> 0

            if (wait_clr)     wait_cnt <= '0;
            else if (wait_en) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign cnt_done = (cnt == CNT_W'(SER_LEN - 1));
    // wait_cnt is 0 on the first MEM cycle, so TIMEOUT-1 marks the TIMEOUT-th.
    assign wait_done = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

endmodule

// File: rtl/serv_bufreg2_seq.sv
// serv_bufreg2_seq
// Sequencer for the bit-serial secondary buffer register (stores, loads,
// shifts). One request at a time: 32-cycle INIT, then bus cycle (store/load)
// or shift wait, then 32-cycle RUN (load/shift).
// Optional build macro: SERV_BUFREG2_SEQ_MISALIGN_TRAP_EN -- misaligned
// load/store accepts skip the bus and return done+err on the next cycle.
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_req, i_op, i_size, i_lsb         request, sampled only when o_ready
//   o_ready, o_done, o_err             handshake/status to core state logic
//   o_en, o_init, o_cnt_done, o_lsb,
//   o_byte_valid, o_shift_op, o_load   buffer controls
//   i_sh_done_r                        registered shift-done from buffer
//   o_dbus_cyc, o_dbus_we, i_dbus_ack  data bus
module serv_bufreg2_seq
    import serv_bufreg2_seq_pkg::*;
#(
    parameter int TIMEOUT = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [1:0] i_op,
    input  logic [1:0] i_size,
    input  logic [1:0] i_lsb,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_err,
    output logic       o_en,
    output logic       o_init,
    output logic       o_cnt_done,
    output logic [1:0] o_lsb,
    output logic       o_byte_valid,
    output logic       o_shift_op,
    output logic       o_load,
    input  logic       i_sh_done_r,
    output logic       o_dbus_cyc,
    output logic       o_dbus_we,
    input  logic       i_dbus_ack
);

`ifdef SERV_BUFREG2_SEQ_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [2:0]       state, state_n;
    logic [1:0]       op_q, size_q, lsb_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done, wait_done;
    logic             in_serial, in_mem;
    logic             is_store, is_load, is_shift;
    logic             lane_ok, trap_req;

    assign in_serial = (state == ST_INIT) || (state == ST_RUN);
    assign in_mem    = (state == ST_MEM);
    assign is_store  = (op_q == OP_STORE);
    assign is_load   = (op_q == OP_LOAD);
    assign is_shift  = (op_q == OP_SHIFT);

    serv_seq_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk       (i_clk),
        .rst       (i_rst),
        .cnt_clr   (!in_serial),
        .cnt_en    (in_serial),
        .wait_clr  (!in_mem),
        .wait_en   (in_mem && !i_dbus_ack),
        .cnt       (cnt),
        .cnt_done  (cnt_done),
        .wait_done (wait_done)
    );

    // Shifts never trap; the reserved op is a store and so can trap.
    assign trap_req = TRAP_EN && (i_op != OP_SHIFT) && misaligned(i_size, i_lsb);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (i_req) state_n = trap_req ? ST_TRAP : ST_INIT;
            ST_INIT:  if (cnt_done) state_n = is_shift ? ST_SHIFT : ST_MEM;
            ST_MEM: begin
                // ack beats a simultaneous timeout
                if (i_dbus_ack)     state_n = is_store ? ST_IDLE : ST_RUN;
                else if (wait_done) state_n = ST_IDLE;
            end
            ST_SHIFT: if (i_sh_done_r) state_n = ST_RUN;
            ST_RUN:   if (cnt_done) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_STORE;
            size_q <= SZ_BYTE;
            lsb_q  <= 2'b00;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && i_req) begin
                op_q   <= (i_op == OP_RSVD) ? OP_STORE : i_op;
                size_q <= i_size;
                lsb_q  <= i_lsb;
            end
        end
    end

    // Load lane qualifier from the byte index cnt[4:3] within the word.
    always_comb begin
        case (size_q)
            SZ_BYTE: lane_ok = (cnt[4:3] == 2'b00);
            SZ_HALF: lane_ok = !cnt[4];
            default: lane_ok = 1'b1;
        endcase
    end

    always_comb begin
        o_ready      = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_en         = 1'b0;
        o_init       = 1'b0;
        o_cnt_done   = 1'b0;
        o_byte_valid = 1'b0;
        o_shift_op   = 1'b0;
        o_load       = 1'b0;
        o_dbus_cyc   = 1'b0;
        o_dbus_we    = 1'b0;
        case (state)
            ST_IDLE: o_ready = 1'b1;
            ST_INIT: begin
                o_en         = 1'b1;
                o_init       = 1'b1;
                o_byte_valid = 1'b1;
                o_shift_op   = is_shift;
                o_cnt_done   = cnt_done;
            end
            ST_MEM: begin
                o_dbus_cyc = 1'b1;
                o_dbus_we  = is_store;
                if (i_dbus_ack) begin
                    o_done = is_store;
                    o_load = is_load;
                end else if (wait_done) begin
                    o_done = 1'b1;
                    o_err  = 1'b1;
                end
            end
            ST_SHIFT: begin
                o_en       = 1'b1;
                o_shift_op = 1'b1;
            end
            ST_RUN: begin
                o_en         = 1'b1;
                o_byte_valid = is_load ? lane_ok : 1'b1;
                o_cnt_done   = cnt_done;
                o_done       = cnt_done;
            end
            ST_TRAP: begin
                o_done = 1'b1;
                o_err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_lsb = lsb_q;

endmodule
